// File: rtl/alu_seq_unit_if.sv
// Request/response bundle for alu_seq_unit: operands and decode fields in, handshake, result and NZCV out.
interface alu_seq_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic             ALUOp;
  logic             MulOp;
  logic [5:0]       Funct;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] Result;
  logic [3:0]       Flags;

  modport master (
    output start, ALUOp, MulOp, Funct, SrcA, SrcB,
    input  busy, done, err, Result, Flags
  );

  modport slave (
    input  start, ALUOp, MulOp, Funct, SrcA, SrcB,
    output busy, done, err, Result, Flags
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Sequenced ALU + NZCV register: single-cycle ops done 1 cycle after accept, shift-add multiply done WIDTH+1 after.
// start taken only in IDLE/DONE and dropped while busy; ALU_SEQ_EARLY_TERM_EN lets multiply exit once the multiplier empties.
module alu_seq_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic           clk,
  input logic           reset,
  alu_seq_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_UND} op_t;

  state_t           state, state_nxt;
  op_t              op;
  logic [1:0]       flagw;
  logic             accept, is_mul, is_sub, mul_last, mul_s, err_q;
  logic [WIDTH-1:0] opb, alu_res, res_q;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
  logic [WIDTH:0]   sum;
  logic [3:0]       flags_q, flags_nxt;
  logic [CNT_W-1:0] cnt;
  logic             busy_c, done_c, err_c;
  logic             unused_funct;

  assign unused_funct = bus.Funct[5];
  assign accept       = bus.start && (state != MUL);
  assign is_mul       = bus.ALUOp && bus.MulOp;
  assign is_sub       = (op == OP_SUB);

  always_comb begin
    op    = OP_ADD;
    flagw = 2'b00;
    if (bus.ALUOp) begin
      case (bus.Funct[4:1])
        4'b0100: op = OP_ADD;
        4'b0010: op = OP_SUB;
        4'b0000: op = OP_AND;
        4'b1100: op = OP_ORR;
        4'b0001: op = OP_EOR;
        default: op = OP_UND;
      endcase
      if (op != OP_UND)
        flagw = {bus.Funct[0], bus.Funct[0] && (op == OP_ADD || op == OP_SUB)};
    end
  end

  // SUB is A + ~B + 1, so C=1 means no borrow
  assign opb = is_sub ? ~bus.SrcB : bus.SrcB;
  assign sum = {1'b0, bus.SrcA} + {1'b0, opb} + (WIDTH+1)'(is_sub);

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD, OP_SUB: alu_res = sum[WIDTH-1:0];
      OP_AND:         alu_res = bus.SrcA & bus.SrcB;
      OP_ORR:         alu_res = bus.SrcA | bus.SrcB;
      OP_EOR:         alu_res = bus.SrcA ^ bus.SrcB;
      default:        alu_res = '0;
    endcase
  end

  always_comb begin
    flags_nxt = flags_q;
    if (flagw[1]) flags_nxt[3:2] = {alu_res[WIDTH-1], alu_res == '0};
    if (flagw[0]) flags_nxt[1:0] = {sum[WIDTH],
                                    (bus.SrcA[WIDTH-1] == opb[WIDTH-1]) &&
                                    (sum[WIDTH-1] != bus.SrcA[WIDTH-1])};
  end

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

`ifdef ALU_SEQ_EARLY_TERM_EN
  assign mul_last = (cnt == CNT_W'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
  assign mul_last = (cnt == CNT_W'(WIDTH - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = is_mul ? MUL : DONE;
        else        state_nxt = IDLE;
      end
      MUL:     if (mul_last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = (state == MUL);
    done_c = (state == DONE);
    err_c  = (state == DONE) && err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q   <= '0;
      flags_q <= 4'b0000;
      err_q   <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      mul_s   <= 1'b0;
    end else if (accept && is_mul) begin
      mcand  <= bus.SrcA;
      mplier <= bus.SrcB;
      acc    <= '0;
      cnt    <= '0;
      mul_s  <= bus.Funct[0];
      err_q  <= 1'b0;
    end else if (accept) begin
      res_q   <= alu_res;
      flags_q <= flags_nxt;
      err_q   <= (op == OP_UND);
    end else if (state == MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (mul_last) begin
        res_q <= acc_nxt;
        if (mul_s) flags_q[3:2] <= {acc_nxt[WIDTH-1], acc_nxt == '0};
      end
    end
  end

  assign bus.busy   = busy_c;
  assign bus.done   = done_c;
  assign bus.err    = err_c;
  assign bus.Result = res_q;
  assign bus.Flags  = flags_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboarded directed bench for alu_seq_unit at WIDTH=32.
module tb_alu_seq_unit;
  localparam int W = 32;

`ifdef ALU_SEQ_EARLY_TERM_EN
  localparam int LAT_MUL37  = 4;
  localparam int BUSY_MUL37 = 3;
  localparam int PULSE_AT   = 1;
  localparam int LAT_MUL16  = 18;
  localparam int LAT_MUL_B0 = 2;
  localparam int LAT_MUL_B2 = 3;
`else
  localparam int LAT_MUL37  = 33;
  localparam int BUSY_MUL37 = 32;
  localparam int PULSE_AT   = 3;
  localparam int LAT_MUL16  = 33;
  localparam int LAT_MUL_B0 = 33;
  localparam int LAT_MUL_B2 = 33;
`endif

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic [3:0]   flags;
    logic         err;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  alu_seq_unit_if #(.WIDTH(W)) bus ();

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done) begin
        chk("done_busy_exclusive", W'(bus.busy), '0);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got done with no request outstanding (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.name, "_cycle"}, W'(cyc), W'(e.cyc));
          chk({e.name, "_result"}, bus.Result, e.res);
          chk({e.name, "_flags"}, W'(bus.Flags), W'(e.flags));
          chk({e.name, "_err"}, W'(bus.err), W'(e.err));
        end
      end else begin
        if (bus.err) begin
          checks++;
          errors++;
          $display("FAIL err_without_done: got err=1 done=0 (cycle %0d)", cyc);
        end
        if (q.size() > 0 && q[0].cyc < cyc) begin
          exp_t e;
          e = q.pop_front();
          checks++;
          errors++;
          $display("FAIL %s_late: no done by cycle %0d expected at %0d", e.name, cyc, e.cyc);
        end
      end
    end
  end

  // Called at a negedge; the request is accepted at the following posedge.
  task automatic issue(input string name, input logic aluop, input logic mulop, input logic [5:0] funct,
                       input logic [W-1:0] a, input logic [W-1:0] b, input bit push,
                       input logic [W-1:0] eres, input logic [3:0] eflags, input logic eerr, input int lat);
    exp_t e;
    bus.start = 1'b1;
    bus.ALUOp = aluop;
    bus.MulOp = mulop;
    bus.Funct = funct;
    bus.SrcA  = a;
    bus.SrcB  = b;
    if (push) begin
      e.name  = name;
      e.res   = eres;
      e.flags = eflags;
      e.err   = eerr;
      e.cyc   = cyc + lat;
      q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.SrcA  = 32'hDEAD_BEEF;
    bus.SrcB  = 32'hA5A5_5A5A;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d requests still outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbusy;
    bus.start = 1'b0;
    bus.ALUOp = 1'b0;
    bus.MulOp = 1'b0;
    bus.Funct = 6'b0;
    bus.SrcA  = '0;
    bus.SrcB  = '0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_done", W'(bus.done), '0);
    chk("rst_err", W'(bus.err), '0);
    chk("rst_result", bus.Result, '0);
    chk("rst_flags", W'(bus.Flags), '0);
    reset = 1'b0;
    @(negedge clk);

    issue("add_ovf", 1, 0, 6'b001001, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000, 4'b1001, 0, 1);
    drain();
    issue("sub_zero", 1, 0, 6'b000101, 32'd5, 32'd5, 1, 32'h0, 4'b0110, 0, 1);
    issue("and_nos", 1, 0, 6'b000000, 32'hF0, 32'h3C, 1, 32'h30, 4'b0110, 0, 1);
    drain();

    // Multiply with a start pulse landing mid-iteration that must be dropped
    issue("mul_3x7", 1, 1, 6'b000001, 32'd3, 32'd7, 1, 32'd21, 4'b0010, 0, LAT_MUL37);
    nbusy = 0;
    for (int i = 0; i < 60 && !bus.done; i++) begin
      if (bus.busy) nbusy++;
      bus.start = (i == PULSE_AT);
      bus.ALUOp = 1'b1;
      bus.MulOp = 1'b0;
      bus.Funct = 6'b001001;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("mul_busy_cycles", W'(nbusy), W'(BUSY_MUL37));
    drain();
    repeat (5) @(negedge clk);

    issue("b2b_add", 1, 0, 6'b001000, 32'd1, 32'd2, 1, 32'd3, 4'b0010, 0, 1);
    issue("b2b_eor", 1, 0, 6'b000010, 32'hFF, 32'h0F, 1, 32'hF0, 4'b0010, 0, 1);
    drain();
    issue("plain_add", 0, 1, 6'b000101, 32'hFFFF_FFFF, 32'h1, 1, 32'h0, 4'b0010, 0, 1);
    issue("orr_s", 1, 0, 6'b011001, 32'h8000_0000, 32'h1, 1, 32'h8000_0001, 4'b1010, 0, 1);
    issue("sub_borrow", 1, 0, 6'b000101, 32'h0, 32'h1, 1, 32'hFFFF_FFFF, 4'b1000, 0, 1);
    issue("undef_cmd", 1, 0, 6'b010101, 32'h1234, 32'h5678, 1, 32'h0, 4'b1000, 1, 1);
    drain();
    issue("mul_wrap", 1, 1, 6'b000001, 32'h0001_0000, 32'h0001_0000, 1, 32'h0, 4'b0100, 0, LAT_MUL16);
    drain();

    // Reset on the tenth multiply cycle: operation abandoned silently
    issue("mul_abort", 1, 1, 6'b000001, 32'd3, 32'hFFFF_FFFF, 0, '0, 4'b0, 0, 0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", W'(bus.busy), '0);
    chk("abort_done", W'(bus.done), '0);
    chk("abort_flags", W'(bus.Flags), '0);
    chk("abort_result", bus.Result, '0);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    issue("mul_b0", 1, 1, 6'b000001, 32'd9, 32'd0, 1, 32'd0, 4'b0100, 0, LAT_MUL_B0);
    drain();
    issue("mul_b2", 1, 1, 6'b000001, 32'd9, 32'd2, 1, 32'd18, 4'b0000, 0, LAT_MUL_B2);
    drain();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
